// File: rtl/dvs_ravens_pkg.sv
// Shared definitions for the DVS->Ravens bus requester slice.
package dvs_ravens_pkg;

  localparam int DVS_RAVENS_BUS_W      = 16;
  localparam int DVS_RAVENS_MAX_BURST  = 4;
  localparam int DVS_RAVENS_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    REQ_IDLE,
    REQ_ACTIVE,
    REQ_RELEASE
  } requester_state_t;

endpackage

// File: rtl/dvs_ravens_event_fifo.sv
// Small synchronous event FIFO with a combinational head so the requester
// can present the oldest word on the bus in the same cycle it is granted.
module dvs_ravens_event_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  // A full FIFO refuses a push even when a pop frees a slot this cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Next pointer/count and storage update; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // Pointer and count registers; reset discards any queued words.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/dvs_ravens_bus_requester.sv
// Master-side requester for the shared DVS->Ravens bus: queues event words,
// requests the bus, transfers on granted cycles and yields after a burst.
module dvs_ravens_bus_requester
  import dvs_ravens_pkg::*;
#(
  parameter int DATA_W     = DVS_RAVENS_BUS_W,
  parameter int FIFO_DEPTH = DVS_RAVENS_FIFO_DEPTH,
  parameter int MAX_BURST  = DVS_RAVENS_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              req,
  input  logic              grant,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  output logic              busy
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  requester_state_t    state_q, state_d;
  logic                req_q, req_d;
  logic [BURST_W-1:0]  burst_cnt_q, burst_cnt_d;

  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [DATA_W-1:0]   fifo_head;
  logic                push;
  logic                pop;
  logic                last_of_burst;
  logic                draining;

  dvs_ravens_event_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  // Handshakes are forced quiet while reset is held so nothing leaks out.
  assign in_ready  = ~rst & ~fifo_full;
  assign push      = in_valid & in_ready;
  assign bus_valid = ~rst & (state_q == REQ_ACTIVE) & grant & ~fifo_empty;
  assign pop       = bus_valid;
  // AND-OR shared bus: drive zeros whenever this master is not transferring.
  assign bus_data  = bus_valid ? fifo_head : '0;
  assign busy      = (state_q != REQ_IDLE) | ~fifo_empty;
  assign req       = req_q;

  assign last_of_burst = (burst_cnt_q + BURST_W'(1)) == BURST_W'(MAX_BURST);
  assign draining      = (fifo_count == CNT_W'(1)) & ~push;

  // State, request and burst counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= REQ_IDLE;
      req_q       <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Next state: leave ACTIVE after the transfer that ends the burst or empties the FIFO.
  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ_IDLE:    if (fifo_count != '0) state_d = REQ_ACTIVE;
      REQ_ACTIVE:  if (pop && (last_of_burst || draining)) state_d = REQ_RELEASE;
      REQ_RELEASE: state_d = REQ_IDLE;
      default:     state_d = REQ_IDLE;
    endcase
  end

  // Outputs: req registered from the next state; burst count survives grant loss.
  always_comb begin
    req_d       = (state_d == REQ_ACTIVE);
    burst_cnt_d = burst_cnt_q;
    if (state_q == REQ_RELEASE) begin
      burst_cnt_d = '0;
    end else if (pop) begin
      burst_cnt_d = burst_cnt_q + BURST_W'(1);
    end
  end

endmodule

// File: tb/tb_dvs_ravens_bus_requester.sv
// Scoreboard bench for dvs_ravens_bus_requester: stimulus pushes expected bus
// words into queues, monitors pop and compare on every bus_valid cycle.
module tb_dvs_ravens_bus_requester;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: default parameters (MAX_BURST = 4)
  logic        in_valid_a, in_ready_a, req_a, grant_a, bus_valid_a, busy_a;
  logic [15:0] in_data_a, bus_data_a;
  logic        tie_a, gman_a;
  assign grant_a = tie_a ? req_a : gman_a;

  // Instance B: MAX_BURST = 2
  logic        in_valid_b, in_ready_b, req_b, grant_b, bus_valid_b, busy_b;
  logic [15:0] in_data_b, bus_data_b;
  logic        tie_b;
  assign grant_b = tie_b ? req_b : 1'b0;

  dvs_ravens_bus_requester dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_data(in_data_a),
    .in_ready(in_ready_a), .req(req_a), .grant(grant_a),
    .bus_valid(bus_valid_a), .bus_data(bus_data_a), .busy(busy_a)
  );

  dvs_ravens_bus_requester #(.MAX_BURST(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_data(in_data_b),
    .in_ready(in_ready_b), .req(req_b), .grant(grant_b),
    .bus_valid(bus_valid_b), .bus_data(bus_data_b), .busy(busy_b)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];
  logic [15:0] e_a, e_b;

  int burst_pat [7] = '{1, 1, 0, 0, 1, 1, 0};
  int rev_grant [7] = '{1, 0, 0, 0, 1, 1, 0};
  int rev_valid [7] = '{1, 0, 0, 0, 1, 1, 0};
  int rev_req   [7] = '{1, 1, 1, 1, 1, 1, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Monitor A: every transferred word must match the oldest expected word.
  always begin
    @(negedge clk);
    #2;
    if (bus_valid_a) begin
      if (exp_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_word: got 0x%0h expected no transfer at %0t", bus_data_a, $time);
      end else begin
        e_a = exp_a.pop_front();
        $display("a transfer data=0x%h expected=0x%h", bus_data_a, e_a);
        chk("a_bus_data", {16'h0, bus_data_a}, {16'h0, e_a});
      end
    end
  end

  // Monitor B: same scoreboard for the short-burst instance.
  always begin
    @(negedge clk);
    #2;
    if (bus_valid_b) begin
      if (exp_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_word: got 0x%0h expected no transfer at %0t", bus_data_b, $time);
      end else begin
        e_b = exp_b.pop_front();
        $display("b transfer data=0x%h expected=0x%h", bus_data_b, e_b);
        chk("b_bus_data", {16'h0, bus_data_b}, {16'h0, e_b});
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid_a = 1'b0; in_data_a = '0; tie_a = 1'b0; gman_a = 1'b0;
    in_valid_b = 1'b0; in_data_b = '0; tie_b = 1'b0;

    // Reset state, with a grant offered to prove it is ignored
    cyc(); cyc();
    gman_a = 1'b1;
    #1;
    chk("rst_in_ready", in_ready_a, 0);
    chk("rst_req", req_a, 0);
    chk("rst_bus_valid", bus_valid_a, 0);
    chk("rst_bus_data", bus_data_a, 0);
    cyc();
    rst = 1'b0; gman_a = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready_a, 1);
    chk("post_rst_busy", busy_a, 0);
    chk("post_rst_req", req_a, 0);

    // Single event, grant tied to req
    cyc(); tie_a = 1'b1; in_valid_a = 1'b1; in_data_a = 16'h1234; exp_a.push_back(16'h1234);
    #1; chk("single_c0_req", req_a, 0);
    cyc(); in_valid_a = 1'b0;
    #1; chk("single_c1_req", req_a, 0); chk("single_c1_busy", busy_a, 1);
    cyc();
    #1; chk("single_c2_req", req_a, 1); chk("single_c2_valid", bus_valid_a, 1);
    cyc();
    #1; chk("single_c3_req", req_a, 0); chk("single_c3_valid", bus_valid_a, 0); chk("single_c3_busy", busy_a, 1);
    cyc();
    #1; chk("single_c4_req", req_a, 0); chk("single_c4_busy", busy_a, 0);
    tie_a = 1'b0;

    // Burst limit on instance B: 4 words, MAX_BURST = 2
    for (int i = 0; i < 4; i++) begin
      cyc(); in_valid_b = 1'b1; in_data_b = 16'h00A0 + 16'(i); exp_b.push_back(16'h00A0 + 16'(i));
      #1; chk("burst_in_ready", in_ready_b, 1);
    end
    for (int k = 0; k < 7; k++) begin
      cyc();
      if (k == 0) begin in_valid_b = 1'b0; tie_b = 1'b1; end
      #1;
      chk("burst_req", req_b, burst_pat[k]);
      chk("burst_valid", bus_valid_b, burst_pat[k]);
    end
    tie_b = 1'b0;
    cyc(); #1; chk("burst_done_busy", busy_b, 0);

    // Full FIFO backpressure, grant low
    for (int i = 0; i < 5; i++) begin
      cyc(); in_valid_a = 1'b1; in_data_a = 16'h00B0 + 16'(i);
      #1; chk("bp_in_ready", in_ready_a, (i < 4) ? 1 : 0);
      if (i < 4) exp_a.push_back(16'h00B0 + 16'(i));
    end
    // Pop on a full FIFO while in_valid is high: 0x00BF must not be accepted
    cyc(); in_valid_a = 1'b1; in_data_a = 16'h00BF; gman_a = 1'b1;
    #1; chk("bp_full_pop_in_ready", in_ready_a, 0); chk("bp_full_pop_valid", bus_valid_a, 1);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      if (k == 1) in_valid_a = 1'b0;
    end
    #1; chk("bp_drained_busy", busy_a, 0); chk("bp_drained_queue", exp_a.size(), 0);
    gman_a = 1'b0;

    // Grant revoked mid-burst: 3 words, grant 1,0,0,0,1,1
    for (int i = 0; i < 3; i++) begin
      cyc(); in_valid_a = 1'b1; in_data_a = 16'h00C0 + 16'(i); exp_a.push_back(16'h00C0 + 16'(i));
      #1;
    end
    for (int k = 0; k < 7; k++) begin
      cyc();
      if (k == 0) in_valid_a = 1'b0;
      gman_a = rev_grant[k][0];
      #1;
      chk("revoke_req", req_a, rev_req[k]);
      chk("revoke_valid", bus_valid_a, rev_valid[k]);
      if (rev_grant[k] == 0) chk("revoke_bus_zero", bus_data_a, 0);
    end
    gman_a = 1'b0;
    cyc(); #1; chk("revoke_done_busy", busy_a, 0);

    // Push coinciding with the transfer of the last word
    cyc(); tie_a = 1'b1; in_valid_a = 1'b1; in_data_a = 16'h00D0; exp_a.push_back(16'h00D0);
    #1;
    cyc(); in_valid_a = 1'b0;
    #1; chk("pp_c1_req", req_a, 0);
    cyc(); in_valid_a = 1'b1; in_data_a = 16'h00D1; exp_a.push_back(16'h00D1);
    #1; chk("pp_c2_valid", bus_valid_a, 1); chk("pp_c2_in_ready", in_ready_a, 1);
    cyc(); in_valid_a = 1'b0;
    #1; chk("pp_c3_req", req_a, 1); chk("pp_c3_valid", bus_valid_a, 1);
    cyc();
    #1; chk("pp_c4_req", req_a, 0);
    cyc(); tie_a = 1'b0;
    #1; chk("pp_done_busy", busy_a, 0);

    // Reset mid-burst with two words queued (never expected on the bus)
    cyc(); in_valid_a = 1'b1; in_data_a = 16'h00E0;
    #1;
    cyc(); in_data_a = 16'h00E1;
    #1;
    cyc(); in_valid_a = 1'b0;
    #1; chk("rmb_active_req", req_a, 1); chk("rmb_active_busy", busy_a, 1);
    cyc(); rst = 1'b1; gman_a = 1'b1;
    #1; chk("rmb_rst_valid", bus_valid_a, 0); chk("rmb_rst_in_ready", in_ready_a, 0); chk("rmb_rst_data", bus_data_a, 0);
    cyc();
    #1; chk("rmb_held_req", req_a, 0); chk("rmb_held_valid", bus_valid_a, 0); chk("rmb_held_in_ready", in_ready_a, 0);
    cyc(); rst = 1'b0;
    #1; chk("rmb_rel_busy", busy_a, 0); chk("rmb_rel_in_ready", in_ready_a, 1); chk("rmb_rel_req", req_a, 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      #1; chk("rmb_no_stale", bus_valid_a, 0);
    end
    gman_a = 1'b0;

    cyc(); cyc();
    chk("a_queue_empty", exp_a.size(), 0);
    chk("b_queue_empty", exp_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
